draw_cursor_grid: RTL and testbench
===================================

# draw_cursor_grid

Clocked, parametrised selection-cursor overlay for the 96x64 OLED pipeline. It keeps a cursor position on a COLS x ROWS grid of square tiles and steps it on rising edges of four debounced direction buttons, with saturating or wrap-around bounds. A centre button toggles a locked (selected) state, in which the border changes colour and blinks. For each incoming pixel_index it produces a registered draw/colour pair for a hollow square border of configurable size and thickness; the layer compositor consumes this pair.

## Interface
- COLS, 5: grid columns (1..8)
- ROWS, 1: grid rows (1..4)
- START_COL, 2 / START_ROW, 0: cursor position after reset
- X0, 6 / Y0, 23: top-left pixel of tile (0,0)
- X_SEP, 16 / Y_SEP, 16: tile pitch in pixels
- SIZE, 14: outer square edge length
- THICK, 3: border thickness; inner hole is SIZE-2*THICK
- WRAP, 0: 0 = saturate at grid edges, 1 = wrap to opposite edge
- BLINK_CYCLES, 3125000: clk cycles per blink half-period in locked state
- COL_NAV, 16'h07E0 / COL_LOCK, 16'hFFE0: RGB565 border colours
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pixel_index  in  13  OLED pixel index, x = idx % 96, y = idx / 96
- btn_l, btn_r, btn_u, btn_d, btn_c  in  1 each  debounced level buttons
- draw  out  1  pixel belongs to the visible border
- colour  out  16  RGB565 colour, meaningful when draw = 1
- cur_col  out  3  current column
- cur_row  out  2  current row
- locked  out  1  1 = selection locked

## Operation
- Edge detect: each button is registered once; edge = btn & ~btn_q. A held button produces exactly one step. Button registers reset to 0, so a button held through reset release produces an edge on the first clock.
- States: NAV and LOCKED.
- NAV: a btn_c edge moves to LOCKED; direction edges in that cycle are discarded. Otherwise the horizontal and vertical axes update independently in the same cycle.
  - L has priority over R; U has priority over D.
  - Left at col 0: stays 0 when WRAP=0, goes to COLS-1 when WRAP=1. Right at COLS-1: symmetric. Rows behave the same way.
  - When COLS=1 or ROWS=1, that axis never changes.
- LOCKED: direction edges are ignored. A btn_c edge returns to NAV.
- Blink:
  - Counter counts 0..BLINK_CYCLES-1, then wraps and toggles phase.
  - Entering LOCKED clears the counter and sets phase=1.
  - In NAV, phase is held at 1 and the counter is held at 0.
- Geometry:
  - sx = X0 + cur_col*X_SEP, sy = Y0 + cur_row*Y_SEP, computed in 8-bit unsigned arithmetic. The parameters must keep sx+SIZE <= 96 and sy+SIZE <= 64.
  - The pixel is in the border when dx = x-sx and dy = y-sy are both in 0..SIZE-1, and not both in THICK..SIZE-1-THICK.
- Output:
  - draw = border & phase & (pixel_index < 6144).
  - colour = COL_LOCK when locked, else COL_NAV.
  - When draw=0, colour is 16'h0000.

## Timing
- Reset values: cur_col=START_COL, cur_row=START_ROW, locked=0, phase=1, blink counter=0, draw=0, colour=0.
- Cursor and locked outputs update on the clk edge after the edge-detect register sees the rise. That is 2 clks from button rise to a new cur_col, cur_row or locked value.
- draw/colour latency is 1 clk after pixel_index. The output reflects cursor state as registered in the same cycle pixel_index is sampled.
- The x/y split is a combinational divide-by-96 that must fit in one clk. Alternatively, add a pipeline stage, in which case latency is fixed at 2 and this document must be updated.
- Asserting rst_n low at any time, including mid-LOCKED or mid-blink, immediately forces all reset values. No state survives reset.

## Test plan
- Reset, defaults -> cur_col=2, cur_row=0, locked=0. pixel 2246 (38,23) -> draw=1, colour=07E0 one clk later. Pixel 2537 (41,26) -> draw=0. Pixel 2536 (40,26) -> draw=1. Pixel 3507 (51,36) -> draw=1. Pixel 2260 (52,23) -> draw=0.
- WRAP=0: three btn_r pulses -> cur_col 3, 4, 4. Five btn_l pulses -> ends at 0. One btn_r held for 100 clks -> exactly one step.
- WRAP=1, COLS=5: btn_l at col 0 -> col 4. btn_r at col 4 -> col 0. ROWS=2, btn_u at row 0 -> row 1.
- btn_l and btn_r rise in the same clk at col 2 -> col 1. btn_c and btn_r rise together in NAV -> locked=1, col unchanged.
- BLINK_CYCLES=4: btn_c edge -> colour=FFE0. Drawing a border pixel, draw follows the pattern 1 for 4 clks, 0 for 4 clks, repeating. Direction pulses while locked -> no move. Second btn_c edge -> NAV, steady draw=1.
- rst_n low while locked mid-blink phase 0 -> locked=0, draw=0 immediately. After release, the cursor returns to START_COL/START_ROW with green steady.

Source files
------------

// File: rtl/draw_cursor_grid.sv
// Selection-cursor overlay: steps a tile cursor from button edges, toggles a
// blinking locked state, and emits a registered draw/colour pair for its border.
module draw_cursor_grid #(
  parameter int          COLS         = 5,
  parameter int          ROWS         = 1,
  parameter int          START_COL    = 2,
  parameter int          START_ROW    = 0,
  parameter int          X0           = 6,
  parameter int          Y0           = 23,
  parameter int          X_SEP        = 16,
  parameter int          Y_SEP        = 16,
  parameter int          SIZE         = 14,
  parameter int          THICK        = 3,
  parameter int          WRAP         = 0,
  parameter int          BLINK_CYCLES = 3125000,
  parameter logic [15:0] COL_NAV      = 16'h07E0,
  parameter logic [15:0] COL_LOCK     = 16'hFFE0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] pixel_index,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_c,
  output logic        draw,
  output logic [15:0] colour,
  output logic [2:0]  cur_col,
  output logic [1:0]  cur_row,
  output logic        locked
);

  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [2:0]  COL_LAST = 3'(COLS - 1);
  localparam logic [1:0]  ROW_LAST = 2'(ROWS - 1);
  localparam logic [12:0] SIZE13   = 13'(SIZE);
  localparam logic [12:0] HOLE_LO  = 13'(THICK);
  localparam logic [12:0] HOLE_HI  = 13'(SIZE - 1 - THICK);
  localparam bit          HAS_HOLE = (SIZE - 2 * THICK) > 0;

  localparam int B_R = 0;
  localparam int B_L = 1;
  localparam int B_D = 2;
  localparam int B_U = 3;
  localparam int B_C = 4;

  typedef enum logic {NAV, LOCKED} state_t;

  state_t           state_q;
  logic [4:0]       btn;
  logic [4:0]       btnPrev_q;
  logic [4:0]       btnEdge_q;
  logic [2:0]       col_q;
  logic [1:0]       row_q;
  logic             phase_q;
  logic [CNT_W-1:0] blinkCnt_q;
  logic             draw_q;
  logic             draw_d;
  logic [15:0]      colour_q;
  logic [15:0]      colour_d;
  logic [12:0]      pixX;
  logic [12:0]      pixY;
  logic [12:0]      dx;
  logic [12:0]      dy;
  logic [7:0]       sx;
  logic [7:0]       sy;
  logic             inBox;
  logic             inHole;

  assign btn = {btn_c, btn_u, btn_d, btn_l, btn_r};

  // The edge itself is registered, giving a two-clock button-to-cursor latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnPrev_q <= '0;
      btnEdge_q <= '0;
    end else begin
      btnPrev_q <= btn;
      btnEdge_q <= btn & ~btnPrev_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NAV;
      col_q      <= 3'(START_COL);
      row_q      <= 2'(START_ROW);
      phase_q    <= 1'b1;
      blinkCnt_q <= '0;
    end else begin
      case (state_q)
        NAV: begin
          phase_q    <= 1'b1;
          blinkCnt_q <= '0;
          if (btnEdge_q[B_C]) begin
            state_q <= LOCKED;
          end else begin
            if (btnEdge_q[B_L]) begin
              if (col_q == 3'd0) col_q <= (WRAP != 0) ? COL_LAST : 3'd0;
              else               col_q <= col_q - 3'd1;
            end else if (btnEdge_q[B_R]) begin
              if (col_q == COL_LAST) col_q <= (WRAP != 0) ? 3'd0 : COL_LAST;
              else                   col_q <= col_q + 3'd1;
            end
            // Up moves toward row 0, matching screen orientation.
            if (btnEdge_q[B_U]) begin
              if (row_q == 2'd0) row_q <= (WRAP != 0) ? ROW_LAST : 2'd0;
              else               row_q <= row_q - 2'd1;
            end else if (btnEdge_q[B_D]) begin
              if (row_q == ROW_LAST) row_q <= (WRAP != 0) ? 2'd0 : ROW_LAST;
              else                   row_q <= row_q + 2'd1;
            end
          end
        end
        LOCKED: begin
          if (btnEdge_q[B_C]) begin
            state_q    <= NAV;
            phase_q    <= 1'b1;
            blinkCnt_q <= '0;
          end else if (blinkCnt_q == CNT_LAST) begin
            blinkCnt_q <= '0;
            phase_q    <= ~phase_q;
          end else begin
            blinkCnt_q <= blinkCnt_q + 1'b1;
          end
        end
        default: state_q <= NAV;
      endcase
    end
  end

  // Offsets wrap to huge values when the pixel lies above/left of the tile.
  always_comb begin
    pixX     = pixel_index % 13'd96;
    pixY     = pixel_index / 13'd96;
    sx       = 8'(X0) + 8'(col_q) * 8'(X_SEP);
    sy       = 8'(Y0) + 8'(row_q) * 8'(Y_SEP);
    dx       = pixX - {5'd0, sx};
    dy       = pixY - {5'd0, sy};
    inBox    = (dx < SIZE13) && (dy < SIZE13);
    inHole   = HAS_HOLE && (dx >= HOLE_LO) && (dx <= HOLE_HI) &&
               (dy >= HOLE_LO) && (dy <= HOLE_HI);
    draw_d   = inBox && !inHole && phase_q && (pixel_index < 13'd6144);
    colour_d = draw_d ? ((state_q == LOCKED) ? COL_LOCK : COL_NAV) : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_q   <= 1'b0;
      colour_q <= 16'h0000;
    end else begin
      draw_q   <= draw_d;
      colour_q <= colour_d;
    end
  end

  assign draw    = draw_q;
  assign colour  = colour_q;
  assign cur_col = col_q;
  assign cur_row = row_q;
  assign locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_draw_cursor_grid.sv
// Randomised scoreboard bench: a saturating and a wrapping cursor share stimulus
// and are compared against a pixel-geometry reference model.
module tb_draw_cursor_grid;

  localparam int NCOLS = 5;
  localparam int NROWS = 2;
  localparam int BLINK = 4;
  localparam int STARTC = 2;
  localparam int STARTR = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] pixel_index = '0;
  logic        btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_c = 1'b0;

  logic        drawA, drawB, lockedA, lockedB;
  logic [15:0] colourA, colourB;
  logic [2:0]  colA, colB;
  logic [1:0]  rowA, rowB;

  always #5 clk = ~clk;

  draw_cursor_grid #(.ROWS(NROWS), .BLINK_CYCLES(BLINK), .WRAP(0)) dutSat (
    .clk(clk), .rst_n(rst_n), .pixel_index(pixel_index),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .btn_c(btn_c),
    .draw(drawA), .colour(colourA), .cur_col(colA), .cur_row(rowA), .locked(lockedA)
  );

  draw_cursor_grid #(.ROWS(NROWS), .BLINK_CYCLES(BLINK), .WRAP(1)) dutWrap (
    .clk(clk), .rst_n(rst_n), .pixel_index(pixel_index),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .btn_c(btn_c),
    .draw(drawB), .colour(colourB), .cur_col(colB), .cur_row(rowB), .locked(lockedB)
  );

  typedef struct {
    int                idx;
    logic [1:0]        draw;
    logic [1:0][15:0]  colour;
    logic [1:0][2:0]   col;
    logic [1:0][1:0]   row;
    logic              locked;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nFail = 0;
  int   cyc = 0;
  int   mCol[2];
  int   mRow[2];
  bit   mLocked;
  int   lockBase;
  logic tbValid = 1'b0;
  logic validPipe;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) validPipe <= 1'b0;
    else        validPipe <= tbValid;
  end

  task automatic checkOutput(string name, int dut, logic [15:0] act, logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, dut, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per probed pixel, one clock after it was issued.
  always @(negedge clk) begin
    exp_t e;
    if (validPipe) begin
      if (sb.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL scoreboard: got output with no expected entry");
      end else begin
        e = sb.pop_front();
        checkOutput("draw",   0, 16'(drawA),   16'(e.draw[0]));
        checkOutput("draw",   1, 16'(drawB),   16'(e.draw[1]));
        checkOutput("colour", 0, colourA,      e.colour[0]);
        checkOutput("colour", 1, colourB,      e.colour[1]);
        checkOutput("cur_col", 0, 16'(colA),   16'(e.col[0]));
        checkOutput("cur_col", 1, 16'(colB),   16'(e.col[1]));
        checkOutput("cur_row", 0, 16'(rowA),   16'(e.row[0]));
        checkOutput("cur_row", 1, 16'(rowB),   16'(e.row[1]));
        checkOutput("locked", 0, 16'(lockedA), 16'(e.locked));
        checkOutput("locked", 1, 16'(lockedB), 16'(e.locked));
      end
    end
  end

  function automatic bit inBorder(int idx, int col, int row);
    int x, y, dx, dy;
    x  = idx % 96;
    y  = idx / 96;
    dx = x - (6 + col * 16);
    dy = y - (23 + row * 16);
    if (dx < 0 || dx >= 14 || dy < 0 || dy >= 14) return 1'b0;
    return !(dx >= 3 && dx <= 10 && dy >= 3 && dy <= 10);
  endfunction

  function automatic bit phaseNow();
    if (!mLocked) return 1'b1;
    return (((cyc - lockBase) / BLINK) % 2) == 0;
  endfunction

  function automatic int stepAxis(int v, int n, bit dec, bit inc, bit wrap);
    int t;
    if (dec)      t = v - 1;
    else if (inc) t = v + 1;
    else          return v;
    if (wrap)     return (t + n) % n;
    if (t < 0)    return 0;
    if (t > n - 1) return n - 1;
    return t;
  endfunction

  function automatic int randPixel();
    int j, x, y;
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 8191));
    j = int'($urandom_range(0, 1));
    x = 5 + mCol[j] * 16 + int'($urandom_range(0, 15));
    y = 22 + mRow[j] * 16 + int'($urandom_range(0, 15));
    return y * 96 + x;
  endfunction

  function automatic int cornerPixel();
    return (23 + mRow[0] * 16) * 96 + 6 + mCol[0] * 16;
  endfunction

  task automatic probe(int idx);
    exp_t e;
    bit   ph;
    bit   d;
    ph = phaseNow();
    pixel_index = 13'(idx);
    e.idx = idx;
    for (int j = 0; j < 2; j++) begin
      d = (idx < 6144) && inBorder(idx, mCol[j], mRow[j]) && ph;
      e.draw[j]   = d;
      e.colour[j] = d ? (mLocked ? 16'hFFE0 : 16'h07E0) : 16'h0000;
      e.col[j]    = 3'(mCol[j]);
      e.row[j]    = 2'(mRow[j]);
    end
    e.locked = mLocked;
    sb.push_back(e);
    tbValid = 1'b1;
    @(negedge clk);
  endtask

  task automatic flush();
    tbValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic probeBatch(int n);
    repeat (n) probe(randPixel());
    flush();
  endtask

  task automatic applyStimulus(bit l, bit r, bit u, bit d, bit c, int hold);
    btn_l = l; btn_r = r; btn_u = u; btn_d = d; btn_c = c;
    if (c) begin
      if (!mLocked) begin
        mLocked  = 1'b1;
        lockBase = cyc + 2;
      end else begin
        mLocked = 1'b0;
      end
    end else if (!mLocked) begin
      for (int j = 0; j < 2; j++) begin
        mCol[j] = stepAxis(mCol[j], NCOLS, l, r, j == 1);
        mRow[j] = stepAxis(mRow[j], NROWS, u, d, j == 1);
      end
    end
    repeat (hold) @(negedge clk);
    btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0; btn_c = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic checkReset();
    checkOutput("rst_col",    0, 16'(colA),    16'(STARTC));
    checkOutput("rst_col",    1, 16'(colB),    16'(STARTC));
    checkOutput("rst_row",    0, 16'(rowA),    16'(STARTR));
    checkOutput("rst_row",    1, 16'(rowB),    16'(STARTR));
    checkOutput("rst_locked", 0, 16'(lockedA), 16'd0);
    checkOutput("rst_locked", 1, 16'(lockedB), 16'd0);
    checkOutput("rst_draw",   0, 16'(drawA),   16'd0);
    checkOutput("rst_draw",   1, 16'(drawB),   16'd0);
    checkOutput("rst_colour", 0, colourA,      16'h0000);
    checkOutput("rst_colour", 1, colourB,      16'h0000);
  endtask

  task automatic resetModel();
    mCol[0] = STARTC; mCol[1] = STARTC;
    mRow[0] = STARTR; mRow[1] = STARTR;
    mLocked = 1'b0;
    lockBase = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int border;
    int guard;
    resetModel();
    repeat (3) @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    probe(2246); probe(2537); probe(2536); probe(3507); probe(2260);
    flush();

    repeat (3) begin applyStimulus(0, 1, 0, 0, 0, 1); probeBatch(4); end
    repeat (5) begin applyStimulus(1, 0, 0, 0, 0, 1); probeBatch(2); end
    applyStimulus(0, 1, 0, 0, 0, 100); probeBatch(4);
    applyStimulus(1, 0, 0, 0, 0, 1); probeBatch(3);
    applyStimulus(1, 0, 0, 0, 0, 1); probeBatch(3);
    applyStimulus(0, 1, 0, 0, 0, 1); probeBatch(3);

    applyStimulus(0, 0, 0, 1, 0, 1); probeBatch(4);
    applyStimulus(0, 0, 0, 1, 0, 1); probeBatch(4);
    applyStimulus(0, 0, 1, 0, 0, 1); probeBatch(4);

    applyStimulus(0, 1, 0, 0, 0, 1); probeBatch(2);
    applyStimulus(1, 1, 0, 0, 0, 1); probeBatch(4);
    applyStimulus(1, 1, 1, 1, 0, 1); probeBatch(4);

    applyStimulus(0, 1, 0, 0, 1, 1);
    border = cornerPixel();
    repeat (20) probe(border);
    flush();
    applyStimulus(1, 0, 0, 0, 0, 1); probeBatch(4);
    applyStimulus(0, 0, 0, 1, 0, 1); probeBatch(4);
    applyStimulus(0, 0, 0, 0, 1, 1);
    repeat (10) probe(border);
    flush();

    applyStimulus(0, 0, 0, 0, 1, 1);
    guard = 0;
    while (phaseNow() && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    #1;
    resetModel();
    checkReset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    border = cornerPixel();
    repeat (10) probe(border);
    flush();
    probeBatch(6);

    repeat (150) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 5) == 0, int'($urandom_range(1, 3)));
      probeBatch(3);
      if (mLocked) begin
        border = cornerPixel();
        repeat (6) probe(border);
        flush();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
